// File: rtl/os_drain_pkg.sv
// Shared types and defaults for the output-stationary result drain.
// sat_signed clamps a sign-extended accumulator into an out_w-bit signed range.
package os_drain_pkg;

    localparam int ROWS_DEF  = 8;
    localparam int COLS_DEF  = 8;
    localparam int ACC_W_DEF = 64;
    localparam int OUT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } state_t;

    // Result stays sign-extended to 64 bits so callers can compare it to the input.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] acc,
                                                      input int                 out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (out_w >= 64) begin
            return acc;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/os_drain_sat.sv
// Combinational ACC_W -> OUT_W converter: truncation by default, signed saturation
// plus clip flag when OS_DRAIN_SAT_EN is defined. Zero latency, no flow control.
module os_drain_sat
    import os_drain_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] dat_o
`ifdef OS_DRAIN_SAT_EN
    ,
    output logic             sat_o
`endif
);

`ifdef OS_DRAIN_SAT_EN
    logic signed [63:0] acc_ext;
    logic signed [63:0] sat_full;

    assign acc_ext  = 64'(signed'(acc_i));
    assign sat_full = sat_signed(acc_ext, OUT_W);
    assign dat_o    = sat_full[OUT_W-1:0];
    assign sat_o    = (sat_full != acc_ext);
`else
    // Upper accumulator bits are intentionally dropped on the truncate path.
    logic unused_acc;
    assign unused_acc = ^acc_i;
    assign dat_o      = acc_i[OUT_W-1:0];
`endif

endmodule

// File: rtl/os_result_drain.sv
// Snapshots all ROWS*COLS accumulators on START, pulses ACC_RST_N, streams row-major.
// Latency: first OUT_VALID 1 cycle after START; DONE 1 cycle after final handshake.
// Backpressure: OUT_* held while OUT_VALID & ~OUT_READY; optional OS_DRAIN_SAT_EN saturation.
module os_result_drain
    import os_drain_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int IDX_W = $clog2(ROWS * COLS)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [ROWS*COLS*ACC_W-1:0]    MAC_IN,
    output logic                          ACC_RST_N,
    output logic                          BUSY,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [OUT_W-1:0]              OUT_DATA,
    output logic [$clog2(ROWS)-1:0]       OUT_ROW,
    output logic [$clog2(COLS)-1:0]       OUT_COL,
    output logic                          OUT_LAST,
`ifdef OS_DRAIN_SAT_EN
    output logic                          SAT_FLAG,
`endif
    output logic                          DONE
);

    localparam int             N        = ROWS * COLS;
    localparam int             ROW_W    = $clog2(ROWS);
    localparam int             COL_W    = $clog2(COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               acc_rst_n_q;
    logic               start_acc;
    logic [ACC_W-1:0]   snap_q [N];
    logic               stream;
    logic               at_last;
    logic [OUT_W-1:0]   conv_dat;
`ifdef OS_DRAIN_SAT_EN
    logic               conv_sat;
`endif

    assign stream  = (state_q == STREAM);
    assign at_last = (cnt_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    start_acc = 1'b1;
                    cnt_d     = '0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                // Counter parks on the last index; only a new START rewinds it.
                if (OUT_READY) begin
                    if (at_last) begin
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_rst_n_q <= ~start_acc;
        end
    end

    // Snapshot is data-only; outputs are gated by state so it needs no reset.
    always_ff @(posedge CLK) begin
        if (start_acc) begin
            for (int i = 0; i < N; i++) begin
                snap_q[i] <= MAC_IN[i*ACC_W +: ACC_W];
            end
        end
    end

    os_drain_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .acc_i (snap_q[cnt_q]),
`ifdef OS_DRAIN_SAT_EN
        .sat_o (conv_sat),
`endif
        .dat_o (conv_dat)
    );

    assign ACC_RST_N = acc_rst_n_q;
    assign BUSY      = (state_q != IDLE);
    assign OUT_VALID = stream;
    assign DONE      = (state_q == FIN);
    assign OUT_DATA  = stream ? conv_dat : '0;
    assign OUT_ROW   = stream ? ROW_W'(int'(cnt_q) / COLS) : '0;
    assign OUT_COL   = stream ? COL_W'(int'(cnt_q) % COLS) : '0;
    assign OUT_LAST  = stream & at_last;
`ifdef OS_DRAIN_SAT_EN
    assign SAT_FLAG  = stream & conv_sat;
`endif

endmodule

// File: tb/tb_os_result_drain.sv
// Directed scoreboard bench for os_result_drain (8x8, 64-bit acc, 32-bit out).
module tb_os_result_drain;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
        logic        flag;
    } exp_t;

    logic                CLK = 1'b0;
    logic                RST;
    logic                START;
    logic [8*8*64-1:0]   MAC_IN;
    logic                ACC_RST_N;
    logic                BUSY;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic [31:0]         OUT_DATA;
    logic [2:0]          OUT_ROW;
    logic [2:0]          OUT_COL;
    logic                OUT_LAST;
    logic                DONE;
`ifdef OS_DRAIN_SAT_EN
    logic                SAT_FLAG;
`endif

    os_result_drain dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .MAC_IN    (MAC_IN),
        .ACC_RST_N (ACC_RST_N),
        .BUSY      (BUSY),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_ROW   (OUT_ROW),
        .OUT_COL   (OUT_COL),
        .OUT_LAST  (OUT_LAST),
`ifdef OS_DRAIN_SAT_EN
        .SAT_FLAG  (SAT_FLAG),
`endif
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          acc_low_cnt = 0;
    int          last_hs_c = -10;
    logic [63:0] m [64];
    exp_t        sb [$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [2:0]  prev_row;
    logic [2:0]  prev_col;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int i, input logic [63:0] v);
        exp_t e;
        e.row  = 3'(i / 8);
        e.col  = 3'(i % 8);
        e.last = (i == 63);
        e.data = v[31:0];
        e.flag = 1'b0;
`ifdef OS_DRAIN_SAT_EN
        if ($signed(v) > 64'sh0000_0000_7FFF_FFFF) begin
            e.data = 32'h7FFF_FFFF;
            e.flag = 1'b1;
        end else if ($signed(v) < -64'sh0000_0000_8000_0000) begin
            e.data = 32'h8000_0000;
            e.flag = 1'b1;
        end
`endif
        return e;
    endfunction

    // Output monitor: scoreboard pops, hold-under-backpressure and DONE timing.
    always @(negedge CLK) begin
        if (RST) begin
            if (prev_stall) begin
                chk("hold_valid", 64'(OUT_VALID), 64'd1);
                chk("hold_data", 64'(OUT_DATA), 64'(prev_data));
                chk("hold_row", 64'(OUT_ROW), 64'(prev_row));
                chk("hold_col", 64'(OUT_COL), 64'(prev_col));
            end
            if (OUT_VALID && OUT_READY) begin
                chk("beat_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data", 64'(OUT_DATA), 64'(e.data));
                    chk("row", 64'(OUT_ROW), 64'(e.row));
                    chk("col", 64'(OUT_COL), 64'(e.col));
                    chk("last", 64'(OUT_LAST), 64'(e.last));
`ifdef OS_DRAIN_SAT_EN
                    chk("sat_flag", 64'(SAT_FLAG), 64'(e.flag));
`endif
                end
                hs_cnt++;
                if (OUT_LAST) last_hs_c = cyc;
            end
            if (DONE) begin
                done_cnt++;
                chk("done_after_last", 64'(cyc), 64'(last_hs_c + 1));
            end
            if (!ACC_RST_N) acc_low_cnt++;
            prev_stall = OUT_VALID && !OUT_READY;
            prev_data  = OUT_DATA;
            prev_row   = OUT_ROW;
            prev_col   = OUT_COL;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_mac();
        for (int i = 0; i < 64; i++) MAC_IN[i*64 +: 64] = m[i];
    endtask

    task automatic do_start(input bit accept);
        START = 1'b1;
        if (accept) begin
            for (int i = 0; i < 64; i++) sb.push_back(mk(i, m[i]));
            hs_cnt = 0;
        end
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!DONE && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(DONE), 64'd1);
    endtask

    task automatic end_of_stream(input string tag);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_beats"}, 64'(hs_cnt), 64'd64);
        sb.delete();
    endtask

    initial begin
        int k_s;
        int acc0;
        int d0;
        int n;
        RST = 1'b0;
        START = 1'b0;
        OUT_READY = 1'b0;
        MAC_IN = '0;
        repeat (2) tick();

        // Reset state
        chk("rst_acc_rst_n", 64'(ACC_RST_N), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_data", 64'(OUT_DATA), 64'd0);
        chk("rst_last", 64'(OUT_LAST), 64'd0);
        RST = 1'b1;
        tick();
        chk("acc_rst_n_rise", 64'(ACC_RST_N), 64'd1);

        // 1: full-rate stream of r*8+c
        for (int i = 0; i < 64; i++) m[i] = 64'(i);
        load_mac();
        OUT_READY = 1'b1;
        acc0 = acc_low_cnt;
        do_start(1'b1);
        k_s = cyc;
        chk("t1_first_valid", 64'(OUT_VALID), 64'd1);
        chk("t1_busy", 64'(BUSY), 64'd1);
        chk("t1_clear_low", 64'(ACC_RST_N), 64'd0);
        tick();
        chk("t1_clear_high", 64'(ACC_RST_N), 64'd1);
        wait_done(200);
        chk("t1_done_cycle", 64'(cyc), 64'(k_s + 64));
        chk("t1_busy_fin", 64'(BUSY), 64'd1);
        end_of_stream("t1");
        tick();
        chk("t1_clear_pulses", 64'(acc_low_cnt - acc0), 64'd1);
        chk("t1_idle", 64'(BUSY), 64'd0);

        // 2: same stream with READY toggling
        OUT_READY = 1'b1;
        do_start(1'b1);
        n = 0;
        while (!DONE && n < 400) begin
            OUT_READY = ~OUT_READY;
            tick();
            n++;
        end
        chk("t2_done_seen", 64'(DONE), 64'd1);
        end_of_stream("t2");
        OUT_READY = 1'b1;
        tick();

        // 3: MAC_IN changes after accept, START mid-stream and during DONE are ignored
        for (int i = 0; i < 64; i++) m[i] = 64'h0000_0123_0000_0000 + 64'(i * 5);
        load_mac();
        acc0 = acc_low_cnt;
        do_start(1'b1);
        MAC_IN = '1;
        repeat (10) tick();
        do_start(1'b0);
        chk("t3_busy_after_restart", 64'(BUSY), 64'd1);
        wait_done(200);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("t3_start_in_fin_ignored", 64'(BUSY), 64'd0);
        chk("t3_no_valid", 64'(OUT_VALID), 64'd0);
        end_of_stream("t3");
        tick();
        chk("t3_clear_pulses", 64'(acc_low_cnt - acc0), 64'd1);

        // 4: reset at beat 20, then restart from (0,0)
        for (int i = 0; i < 64; i++) m[i] = 64'(i * 7);
        load_mac();
        do_start(1'b1);
        n = 0;
        while (hs_cnt < 20 && n < 100) begin
            tick();
            n++;
        end
        chk("t4_reached_beat20", 64'(hs_cnt), 64'd20);
        d0 = done_cnt;
        RST = 1'b0;
        #1;
        chk("t4_valid", 64'(OUT_VALID), 64'd0);
        chk("t4_busy", 64'(BUSY), 64'd0);
        chk("t4_acc_rst_n", 64'(ACC_RST_N), 64'd0);
        chk("t4_done", 64'(DONE), 64'd0);
        sb.delete();
        repeat (3) tick();
        RST = 1'b1;
        tick();
        chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        for (int i = 0; i < 64; i++) m[i] = 64'(i);
        load_mac();
        do_start(1'b1);
        chk("t4_restart_row", 64'(OUT_ROW), 64'd0);
        chk("t4_restart_col", 64'(OUT_COL), 64'd0);
        wait_done(200);
        end_of_stream("t4");
        tick();

        // 5: width conversion corner values
        for (int i = 0; i < 64; i++) m[i] = 64'(i);
        m[0] = 64'h0000_0001_0000_0000;
        m[1] = 64'hFFFF_FFFF_7FFF_FFFB;
        m[2] = 64'h0000_0000_7FFF_FFFF;
        load_mac();
        do_start(1'b1);
        wait_done(200);
        end_of_stream("t5");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/os_result_drain.md
Name: os_result_drain

Overview:
Readout engine for the output-stationary systolic array: the consumer of the per-PE 64-bit accumulator outputs.
- On START it snapshots all ROWS x COLS accumulators in one cycle and pulses the array accumulator clear.
- It then streams the results row-major over a valid/ready interface to the writeback path, so the array can begin the next tile while the drain runs.

Parameters:
ROWS, 8, PE rows in the array
COLS, 8, PE columns in the array
ACC_W, 64, accumulator width per PE (2 x operand width 32)
OUT_W, 32, output data width; must be <= ACC_W
IDX_W, $clog2(ROWS*COLS), element counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
START  in  1  one-cycle request: the accumulators are final, drain them
MAC_IN  in  ROWS*COLS*ACC_W  flattened accumulators; element (r,c) at bits [(r*COLS+c)*ACC_W +: ACC_W], signed two's complement
ACC_RST_N  out  1  registered active-low accumulator clear to the array
BUSY  out  1  drain in progress
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  downstream accepts
OUT_DATA  out  OUT_W  result value
OUT_ROW  out  $clog2(ROWS)  row index of current element
OUT_COL  out  $clog2(COLS)  column index of current element
OUT_LAST  out  1  current element is (ROWS-1, COLS-1)
DONE  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset values: all outputs 0, including ACC_RST_N=0 (the array is held cleared during reset). State=IDLE, counter=0.
  - ACC_RST_N rises on the first clock edge after RST deasserts.
- States: IDLE, STREAM, FIN.

IDLE:
- BUSY=0, OUT_VALID=0.
- START=1 at edge t:
  - snapshot register <= MAC_IN
  - counter <= 0
  - ACC_RST_N <= 0 for exactly one cycle (cycle t+1), then 1
  - state <= STREAM
- Resulting cycle t+1: BUSY=1, OUT_VALID=1, element (0,0) presented. Latency START to first valid = 1 cycle.

STREAM:
- OUT_DATA/ROW/COL/LAST are driven from snapshot[counter].
- A handshake (OUT_VALID & OUT_READY) at an edge advances the counter.
- While OUT_VALID & ~OUT_READY, all OUT_* stay stable; OUT_VALID never drops without a handshake.
- OUT_LAST=1 iff counter == ROWS*COLS-1.
- Handshake with OUT_LAST: state <= FIN, OUT_VALID <= 0.

FIN:
- DONE=1 for one cycle, BUSY=1 in this cycle, then state <= IDLE.
- Total: ROWS*COLS handshakes per START; back-to-back READY gives 64 consecutive valid cycles.

Rules and boundary conditions:
- Ordering: row-major, col fastest. The counter wraps to 0 only via a new START.
- START while BUSY (STREAM or FIN): ignored. There is no re-snapshot and no clear pulse.
- START in the same cycle DONE is high (FIN): ignored. START is accepted in IDLE only, earliest one cycle after DONE.
- RST asserted mid-stream: immediate IDLE, all outputs to reset values. Partial results are discarded and no DONE is produced.
- MAC_IN is sampled only at the accepting edge; later changes do not affect streamed data.
- Width conversion (macro absent): OUT_DATA = low OUT_W bits of the accumulator (truncation). If OUT_W == ACC_W, it is a pass-through.

Optional Feature:
Macro OS_DRAIN_SAT_EN.
- Defined:
  - OUT_DATA is the accumulator signed-saturated to OUT_W: values > 2^(OUT_W-1)-1 give 2^(OUT_W-1)-1; values < -2^(OUT_W-1) give -2^(OUT_W-1).
  - Extra output port SAT_FLAG (1 bit), valid with OUT_VALID, high when the current element was clipped.
  - Saturation is combinational on the snapshot element and adds no latency.
- Undefined: truncation as above. SAT_FLAG port does not exist.

Decomposition:
- Package os_drain_pkg holds:
  - state enum (IDLE, STREAM, FIN)
  - default ROWS/COLS/ACC_W/OUT_W constants
  - function sat_signed(acc, out_w)
- Sub-module os_drain_sat: combinational ACC_W to OUT_W converter. It holds both the truncate and saturate paths selected by OS_DRAIN_SAT_EN, plus the SAT_FLAG output.
- FSM, counter, snapshot and clear pulse stay in os_result_drain.

Test Plan:
- Reset then START with MAC_IN(r,c)=r*8+c, OUT_READY=1. Required:
  - first OUT_VALID 1 cycle after START, ACC_RST_N low exactly that cycle
  - 64 beats with OUT_DATA 0..63, row/col matching
  - OUT_LAST on beat 64, DONE 1 cycle after
- Same stream with OUT_READY toggled 1,0,1,0. Required: OUT_DATA/ROW/COL held during READY=0, no duplicates or drops, DONE after the 64th handshake.
- Change MAC_IN to all 0xFFFF_FFFF_FFFF_FFFF one cycle after START and pulse START again mid-stream. Required: streamed data is still the original snapshot, no second ACC_RST_N pulse.
- Assert RST at beat 20. Required: OUT_VALID=0, BUSY=0, ACC_RST_N=0 during reset, no DONE. A new START after reset streams from (0,0).
- Element values 0x0000_0001_0000_0000, -2^31-5 and 0x7FFF_FFFF:
  - without OS_DRAIN_SAT_EN: 0x0000_0000, 0x7FFF_FFFB, 0x7FFF_FFFF
  - with OS_DRAIN_SAT_EN: 0x7FFF_FFFF, 0x8000_0000, 0x7FFF_FFFF, with SAT_FLAG 1,1,0
